// File: rtl/ps2_key_decoder_pkg.sv
// Scan-code constants, key indices and the scan-code to key lookup shared by the keyboard front end.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;

    localparam int NUM_KEYS = 7;

    typedef enum logic [2:0] {
        KEY_A     = 3'd0,
        KEY_D     = 3'd1,
        KEY_W     = 3'd2,
        KEY_SPACE = 3'd3,
        KEY_LEFT  = 3'd4,
        KEY_RIGHT = 3'd5,
        KEY_UP    = 3'd6
    } key_idx_e;

    typedef struct packed {
        logic     hit;
        key_idx_e idx;
    } key_match_t;

    // Extended and plain codes live in separate namespaces: ext 1C is not the A key.
    function automatic key_match_t key_lookup(input logic [7:0] code, input logic ext);
        key_match_t m;
        m.hit = 1'b1;
        m.idx = KEY_A;
        if (!ext) begin
            case (code)
                SC_A:     m.idx = KEY_A;
                SC_D:     m.idx = KEY_D;
                SC_W:     m.idx = KEY_W;
                SC_SPACE: m.idx = KEY_SPACE;
                default:  m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_LEFT:  m.idx = KEY_LEFT;
                SC_RIGHT: m.idx = KEY_RIGHT;
                SC_UP:    m.idx = KEY_UP;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF sync, falling-edge detect, 11-bit frame FSM with parity/stop/timeout checks.
// Latency: byte_valid/frame_err one cycle after the stop-bit edge is detected (edge seen 3 cycles after ps2_clk falls).
// Backpressure: none; the keyboard cannot be stalled, results are single-cycle pulses.
module ps2_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift_r;
    logic [TW-1:0] tmo_cnt;
    logic          fall;

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            // Sync stages reset to the idle line level so reset release never fakes an edge.
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            clk_prev   <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_r    <= '0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_prev   <= clk_s2;
            dat_s1     <= ps2_data;
            dat_s2     <= dat_s1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (fall && !dat_s2) begin
                        state   <= ST_RECV;
                        bit_cnt <= 4'd1;
                    end
                end
                default: begin
                    if (fall) begin
                        if (bit_cnt == 4'd10) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            if ((^shift_r) && dat_s2) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shift_r[7:0];
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            // After nine shifts [7:0] holds the data byte and [8] the parity bit.
                            shift_r <= {dat_s2, shift_r[8:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        bit_cnt   <= '0;
                        tmo_cnt   <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Keyboard front end: PS/2 receiver plus E0/F0 prefix tracking and per-key pressed state for left/right/jump.
// Latency: key levels change two cycles after the stop-bit edge is detected.
// Backpressure: none; every good byte is consumed in the cycle it is reported.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic                ext_flag;
    logic                brk_flag;
    logic [NUM_KEYS-1:0] pressed;
    key_match_t          key_m;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_comb begin
        key_m = key_lookup(byte_data, ext_flag);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            pressed  <= '0;
        end else if (frame_err) begin
            // A corrupted byte may have been the tail of a prefix sequence, so drop pending prefixes.
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == SC_E0) begin
                ext_flag <= 1'b1;
            end else if (byte_data == SC_F0) begin
                brk_flag <= 1'b1;
            end else if (byte_data != SC_E1) begin
                if (key_m.hit) begin
                    pressed[key_m.idx] <= ~brk_flag;
                end
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    // Opposing directions are both reported; downstream logic arbitrates.
    assign left  = pressed[KEY_A] | pressed[KEY_LEFT];
    assign right = pressed[KEY_D] | pressed[KEY_RIGHT];
    assign jump  = pressed[KEY_W] | pressed[KEY_SPACE] | pressed[KEY_UP];

endmodule
